gpio_wake_retention: RTL and testbench

Parametrised always-on pad retention and GPIO wake controller for the safe domain. It sits between the SoC GPIO/pad-config outputs and the pad multiplexer. Per channel it synchronises and debounces pad inputs and detects configurable wake edges. On a sleep request it freezes pad output, direction and config state into retention registers, holds them until a wake event occurs, then hands control back to the SoC.

---
 rtl/gpio_wake_retention.sv | 236 +++++++++++++++++++++++
 tb/tb_gpio_wake_retention.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_wake_retention.sv
// gpio_wake_retention
// Always-on pad retention and GPIO wake controller. Synchronises and debounces
// pad inputs, flags configurable wake edges, and on a sleep request freezes the
// pad output/direction/config into retention registers until a wake event has
// been seen and the SoC releases the pads again.
module gpio_wake_retention #(
    parameter  int NB_GPIO     = 32,
    parameter  int CFG_W       = 6,
    parameter  int SYNC_STAGES = 2,
    parameter  int DEB_W       = 4,
    localparam int ID_W        = (NB_GPIO > 1) ? $clog2(NB_GPIO) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NB_GPIO-1:0]         gpio_in_i,
    output logic [NB_GPIO-1:0]         gpio_in_o,
    input  logic [NB_GPIO-1:0]         gpio_out_i,
    input  logic [NB_GPIO-1:0]         gpio_dir_i,
    input  logic [NB_GPIO*CFG_W-1:0]   gpio_cfg_i,
    output logic [NB_GPIO-1:0]         gpio_out_o,
    output logic [NB_GPIO-1:0]         gpio_dir_o,
    output logic [NB_GPIO*CFG_W-1:0]   gpio_cfg_o,
    input  logic [2*NB_GPIO-1:0]       wake_mode_i,
    input  logic [DEB_W-1:0]           deb_thr_i,
    input  logic                       sleep_req_i,
    output logic                       sleep_ack_o,
    input  logic                       release_i,
    output logic                       retain_o,
    output logic                       wake_o,
    output logic [ID_W-1:0]            wake_id_o,
    output logic [NB_GPIO-1:0]         wake_status_o,
    input  logic [NB_GPIO-1:0]         status_clr_i
);

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_FREEZE = 2'b01,
        ST_RETAIN = 2'b10,
        ST_WAKE   = 2'b11
    } state_t;

    localparam logic [NB_GPIO-1:0]       ZERO_G   = {NB_GPIO{1'b0}};
    localparam logic [NB_GPIO*CFG_W-1:0] ZERO_CFG = {(NB_GPIO*CFG_W){1'b0}};
    localparam logic [DEB_W-1:0]         ZERO_CNT = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]         ONE_CNT  = DEB_W'(1'b1);
    localparam logic [ID_W-1:0]          ZERO_ID  = {ID_W{1'b0}};

    // Lowest-index set bit of a status vector; returns zero for an empty vector.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NB_GPIO-1:0] vec);
        logic [ID_W-1:0] idx;
        idx = ZERO_ID;
        for (int i = NB_GPIO - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NB_GPIO-1:0]       sync_r [SYNC_STAGES];
    logic [NB_GPIO-1:0]       sync_s;
    logic [NB_GPIO-1:0]       filt_r;
    logic [NB_GPIO-1:0]       filt_nxt_s;
    logic [DEB_W-1:0]         cnt_r     [NB_GPIO];
    logic [DEB_W-1:0]         cnt_nxt_s [NB_GPIO];
    logic [NB_GPIO-1:0]       toggle_s;
    logic [NB_GPIO-1:0]       event_s;
    logic [NB_GPIO-1:0]       status_r;

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic                     capture_s;
    logic                     wake_cap_s;
    logic                     retain_r;
    logic                     ack_r;
    logic                     wake_r;
    logic [ID_W-1:0]          wake_id_r;
    logic [NB_GPIO-1:0]       ret_out_r;
    logic [NB_GPIO-1:0]       ret_dir_r;
    logic [NB_GPIO*CFG_W-1:0] ret_cfg_r;

    // Multi-stage synchroniser for the raw pad inputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= ZERO_G;
            end
        end else begin
            sync_r[0] <= gpio_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_s    = sync_r[SYNC_STAGES-1];
    assign gpio_in_o = sync_s;

    // Debounce next-state and edge-matched wake event detection per channel.
    always_comb begin
        filt_nxt_s = filt_r;
        toggle_s   = ZERO_G;
        event_s    = ZERO_G;
        for (int k = 0; k < NB_GPIO; k++) begin
            cnt_nxt_s[k] = cnt_r[k];
            if (sync_s[k] == filt_r[k]) begin
                cnt_nxt_s[k] = ZERO_CNT;
            end else if (cnt_r[k] == deb_thr_i) begin
                filt_nxt_s[k] = ~filt_r[k];
                toggle_s[k]   = 1'b1;
                cnt_nxt_s[k]  = ZERO_CNT;
            end else begin
                cnt_nxt_s[k] = cnt_r[k] + ONE_CNT;
            end
            // Old filt value 0 means a rising edge, 1 means a falling edge.
            event_s[k] = toggle_s[k] &
                         ((~filt_r[k] & wake_mode_i[2*k]) |
                          ( filt_r[k] & wake_mode_i[2*k+1]));
        end
    end

    // Debounce filter and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_r <= ZERO_G;
            for (int k = 0; k < NB_GPIO; k++) begin
                cnt_r[k] <= ZERO_CNT;
            end
        end else begin
            filt_r <= filt_nxt_s;
            for (int k = 0; k < NB_GPIO; k++) begin
                cnt_r[k] <= cnt_nxt_s[k];
            end
        end
    end

    // Sticky wake status; a new event beats a simultaneous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            status_r <= ZERO_G;
        end else begin
            status_r <= (status_r & ~status_clr_i) | event_s;
        end
    end

    // Sleep/wake sequencing: next state and capture strobes.
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        wake_cap_s  = 1'b0;
        case (state_r)
            ST_ACTIVE: begin
                if (sleep_req_i) begin
                    state_nxt_s = ST_FREEZE;
                    capture_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_FREEZE: begin
                state_nxt_s = ST_RETAIN;
            end
            ST_RETAIN: begin
                // Any pending status bit wakes, including one left set before sleep.
                if (|status_r) begin
                    state_nxt_s = ST_WAKE;
                    wake_cap_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RETAIN;
                end
            end
            ST_WAKE: begin
                if (release_i) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_WAKE;
                end
            end
            default: begin
                state_nxt_s = ST_ACTIVE;
            end
        endcase
    end

    // State register with registered status flags decoded from the next state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= ST_ACTIVE;
            retain_r  <= 1'b0;
            ack_r     <= 1'b0;
            wake_r    <= 1'b0;
            wake_id_r <= ZERO_ID;
        end else begin
            state_r  <= state_nxt_s;
            retain_r <= (state_nxt_s != ST_ACTIVE);
            ack_r    <= (state_nxt_s == ST_RETAIN);
            wake_r   <= (state_nxt_s == ST_WAKE);
            if (wake_cap_s) begin
                wake_id_r <= lowest_idx(status_r);
            end else begin
                wake_id_r <= wake_id_r;
            end
        end
    end

    // Retention registers sample the live pad controls on the sleep request edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ret_out_r <= ZERO_G;
            ret_dir_r <= ZERO_G;
            ret_cfg_r <= ZERO_CFG;
        end else if (capture_s) begin
            ret_out_r <= gpio_out_i;
            ret_dir_r <= gpio_dir_i;
            ret_cfg_r <= gpio_cfg_i;
        end else begin
            ret_out_r <= ret_out_r;
            ret_dir_r <= ret_dir_r;
            ret_cfg_r <= ret_cfg_r;
        end
    end

    // Pad mux: live pass-through while active, retained values otherwise.
    assign gpio_out_o    = retain_r ? ret_out_r : gpio_out_i;
    assign gpio_dir_o    = retain_r ? ret_dir_r : gpio_dir_i;
    assign gpio_cfg_o    = retain_r ? ret_cfg_r : gpio_cfg_i;

    assign retain_o      = retain_r;
    assign sleep_ack_o   = ack_r;
    assign wake_o        = wake_r;
    assign wake_id_o     = wake_id_r;
    assign wake_status_o = status_r;

endmodule

// File: tb/tb_gpio_wake_retention.sv
// Directed testbench for gpio_wake_retention with default parameters
// (32 channels, 6 config bits, 2 sync stages, 4-bit debounce counter).
module tb_gpio_wake_retention;

    localparam int NB   = 32;
    localparam int CW   = 6;
    localparam int ID_W = 5;

    logic                clk;
    logic                rst;
    logic [NB-1:0]       gpio_in_i;
    logic [NB-1:0]       gpio_in_o;
    logic [NB-1:0]       gpio_out_i;
    logic [NB-1:0]       gpio_dir_i;
    logic [NB*CW-1:0]    gpio_cfg_i;
    logic [NB-1:0]       gpio_out_o;
    logic [NB-1:0]       gpio_dir_o;
    logic [NB*CW-1:0]    gpio_cfg_o;
    logic [2*NB-1:0]     wake_mode;
    logic [3:0]          deb_thr;
    logic                sleep_req;
    logic                sleep_ack;
    logic                release_s;
    logic                retain;
    logic                wake;
    logic [ID_W-1:0]     wake_id;
    logic [NB-1:0]       wake_status;
    logic [NB-1:0]       status_clr;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [NB*CW-1:0] CFG_PAT = {6{32'h1234_5678}};

    gpio_wake_retention dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .gpio_in_i     (gpio_in_i),
        .gpio_in_o     (gpio_in_o),
        .gpio_out_i    (gpio_out_i),
        .gpio_dir_i    (gpio_dir_i),
        .gpio_cfg_i    (gpio_cfg_i),
        .gpio_out_o    (gpio_out_o),
        .gpio_dir_o    (gpio_dir_o),
        .gpio_cfg_o    (gpio_cfg_o),
        .wake_mode_i   (wake_mode),
        .deb_thr_i     (deb_thr),
        .sleep_req_i   (sleep_req),
        .sleep_ack_o   (sleep_ack),
        .release_i     (release_s),
        .retain_o      (retain),
        .wake_o        (wake),
        .wake_id_o     (wake_id),
        .wake_status_o (wake_status),
        .status_clr_i  (status_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        gpio_in_i  = 32'h0000_0200;
        gpio_out_i = 32'h1111_2222;
        gpio_dir_i = 32'h3333_4444;
        gpio_cfg_i = CFG_PAT;
        wake_mode  = 64'h0;
        wake_mode[11:10] = 2'b01;  // ch5 rising
        wake_mode[19:18] = 2'b10;  // ch9 falling
        wake_mode[7:6]   = 2'b11;  // ch3 any
        wake_mode[15:14] = 2'b01;  // ch7 rising
        wake_mode[1:0]   = 2'b01;  // ch0 rising
        deb_thr    = 4'd3;
        sleep_req  = 1'b0;
        release_s  = 1'b0;
        status_clr = 32'h0;

        // Reset state: everything quiet, pads pass through.
        step(3);
        chk("rst_retain", {191'd0, retain}, 192'd0);
        chk("rst_ack", {191'd0, sleep_ack}, 192'd0);
        chk("rst_wake", {191'd0, wake}, 192'd0);
        chk("rst_status", {160'd0, wake_status}, 192'd0);
        chk("rst_id", {187'd0, wake_id}, 192'd0);
        chk("rst_gpio_in", {160'd0, gpio_in_o}, 192'd0);
        chk("rst_out_pass", {160'd0, gpio_out_o}, {160'd0, 32'h1111_2222});
        chk("rst_dir_pass", {160'd0, gpio_dir_o}, {160'd0, 32'h3333_4444});
        rst = 1'b0;
        step(10);
        chk("ch9_settle_no_event", {160'd0, wake_status}, 192'd0);

        // Glitch of 3 cycles on ch5 with threshold 3: no event.
        gpio_in_i = 32'h0000_0220;
        step(1);
        chk("sync_lat1", {191'd0, gpio_in_o[5]}, 192'd0);
        step(1);
        chk("sync_lat2", {191'd0, gpio_in_o[5]}, 192'd1);
        step(1);
        gpio_in_i = 32'h0000_0200;
        step(8);
        chk("glitch_no_event", {160'd0, wake_status}, 192'd0);

        // Stable rise on ch5: status exactly 2+3+1 cycles later.
        gpio_in_i = 32'h0000_0220;
        step(5);
        chk("deb_early", {160'd0, wake_status}, 192'd0);
        step(1);
        chk("deb_set", {160'd0, wake_status}, {160'd0, 32'h0000_0020});
        status_clr = 32'h0000_0020;
        step(1);
        status_clr = 32'h0;
        chk("clr_ch5", {160'd0, wake_status}, 192'd0);

        // Clear/set collision on ch7.
        gpio_in_i = 32'h0000_02A0;
        step(5);
        status_clr = 32'h0000_0080;
        step(1);
        chk("collide_set_wins", {160'd0, wake_status}, {160'd0, 32'h0000_0080});
        step(1);
        chk("clear_next", {160'd0, wake_status}, 192'd0);
        status_clr = 32'h0;

        // Retention freeze.
        gpio_out_i = 32'hA5A5_0F0F;
        gpio_dir_i = 32'hFFFF_0000;
        gpio_cfg_i = CFG_PAT;
        #1;
        chk("active_pass", {160'd0, gpio_out_o}, {160'd0, 32'hA5A5_0F0F});
        sleep_req = 1'b1;
        step(1);
        sleep_req  = 1'b0;
        gpio_out_i = 32'h0;
        gpio_dir_i = 32'h0;
        gpio_cfg_i = '0;
        #1;
        chk("freeze_retain", {191'd0, retain}, 192'd1);
        chk("freeze_ack", {191'd0, sleep_ack}, 192'd0);
        chk("freeze_out", {160'd0, gpio_out_o}, {160'd0, 32'hA5A5_0F0F});
        chk("freeze_dir", {160'd0, gpio_dir_o}, {160'd0, 32'hFFFF_0000});
        chk("freeze_cfg", gpio_cfg_o, CFG_PAT);
        step(1);
        chk("retain_ack", {191'd0, sleep_ack}, 192'd1);
        chk("retain_nowake", {191'd0, wake}, 192'd0);

        // Wake priority: ch9 falls and ch3 rises together.
        gpio_in_i = 32'h0000_00A8;
        step(5);
        chk("wake_early_status", {160'd0, wake_status}, 192'd0);
        step(1);
        chk("wake_status_both", {160'd0, wake_status}, {160'd0, 32'h0000_0208});
        chk("wake_not_yet", {191'd0, wake}, 192'd0);
        step(1);
        chk("wake_level", {191'd0, wake}, 192'd1);
        chk("wake_id3", {187'd0, wake_id}, 192'd3);
        chk("wake_ack_low", {191'd0, sleep_ack}, 192'd0);
        chk("wake_retain", {191'd0, retain}, 192'd1);
        gpio_out_i = 32'h1357_9BDF;
        #1;
        chk("wake_out_held", {160'd0, gpio_out_o}, {160'd0, 32'hA5A5_0F0F});
        release_s = 1'b1;
        step(1);
        release_s = 1'b0;
        chk("rel_wake", {191'd0, wake}, 192'd0);
        chk("rel_retain", {191'd0, retain}, 192'd0);
        chk("rel_ack", {191'd0, sleep_ack}, 192'd0);
        chk("rel_live", {160'd0, gpio_out_o}, {160'd0, 32'h1357_9BDF});

        // Pending status on ch0 wakes straight after entering retention.
        status_clr = 32'hFFFF_FFFF;
        step(1);
        status_clr = 32'h0;
        chk("clr_all", {160'd0, wake_status}, 192'd0);
        gpio_in_i = 32'h0000_00A9;
        step(6);
        chk("ch0_status", {160'd0, wake_status}, 192'd1);
        sleep_req = 1'b1;
        step(1);
        sleep_req = 1'b0;
        chk("pend_freeze", {190'd0, retain, sleep_ack}, 192'd2);
        step(1);
        chk("pend_retain", {189'd0, retain, sleep_ack, wake}, 192'd6);
        step(1);
        chk("pend_wake", {189'd0, retain, sleep_ack, wake}, 192'd5);
        chk("pend_id0", {187'd0, wake_id}, 192'd0);

        // Asynchronous reset while in RETAIN.
        release_s = 1'b1;
        step(1);
        release_s = 1'b0;
        status_clr = 32'hFFFF_FFFF;
        step(1);
        status_clr = 32'h0;
        gpio_out_i = 32'hDEAD_BEEF;
        sleep_req  = 1'b1;
        step(1);
        sleep_req = 1'b0;
        step(1);
        chk("rr_in_retain", {191'd0, sleep_ack}, 192'd1);
        gpio_out_i = 32'h0F0F_1234;
        #1;
        chk("rr_held", {160'd0, gpio_out_o}, {160'd0, 32'hDEAD_BEEF});
        #2;
        rst = 1'b1;
        #1;
        chk("rr_flags", {189'd0, retain, sleep_ack, wake}, 192'd0);
        chk("rr_out_live", {160'd0, gpio_out_o}, {160'd0, 32'h0F0F_1234});
        chk("rr_status", {160'd0, wake_status}, 192'd0);
        step(2);
        chk("rr_hold_flags", {189'd0, retain, sleep_ack, wake}, 192'd0);
        rst = 1'b0;
        step(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
